// File: rtl/cnt_step_gen.sv
// cnt_step_gen
//   Stimulus generator for an up/down counter (counter_inc_dec). A target
//   count is accepted over a valid/ready handshake and the generator emits
//   single-cycle inc or dec pulses that walk the downstream counter to that
//   target. A shadow copy of the expected count is checked against the
//   counter's output every cycle; any mismatch sets a sticky error flag.
//
// Parameters
//   WIDTH    : counter / target / shadow / feedback width
//   GAP      : idle cycles between consecutive pulses (0 = back-to-back)
//   SHORTEST : 1 = walk in the shorter modular direction, 0 = always increment
//
// Ports
//   clk        : clock
//   rst_n      : asynchronous reset, active-high
//   tgt_valid  : target request valid
//   tgt_data   : requested target count
//   tgt_ready  : generator can accept a target
//   abort      : stop the current walk (honoured only while walking)
//   cnt_fb     : count output of the driven counter
//   inc / dec  : single-cycle step pulses to the counter (never both high)
//   busy       : walk in progress
//   done       : one-cycle pulse when the target is reached
//   aborted    : one-cycle pulse when a walk is aborted
//   err        : sticky cnt_fb / shadow mismatch
//   shadow     : expected counter value
module cnt_step_gen #(
    parameter int WIDTH    = 8,
    parameter int GAP      = 0,
    parameter bit SHORTEST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tgt_valid,
    input  logic [WIDTH-1:0] tgt_data,
    output logic             tgt_ready,
    input  logic             abort,
    input  logic [WIDTH-1:0] cnt_fb,
    output logic             inc,
    output logic             dec,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic             err,
    output logic [WIDTH-1:0] shadow
);

    localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
    localparam logic [WIDTH-1:0] HALF = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, STEP, WAIT, FIN} state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] rem, rem_n;       // pulses still to issue, current STEP included
    logic             dir, dir_n;       // 0 = increment, 1 = decrement
    logic [GW-1:0]    gap_cnt, gap_n;
    logic [WIDTH-1:0] diff;
    logic             inc_n, dec_n, busy_n, ready_n, done_n, aborted_n;

    always_comb begin
        state_n   = state;
        rem_n     = rem;
        dir_n     = dir;
        gap_n     = gap_cnt;
        aborted_n = 1'b0;
        diff      = tgt_data - shadow;

        unique case (state)
            IDLE, FIN: begin
                state_n = IDLE;
                if (tgt_valid) begin
                    if (diff == '0) begin
                        state_n = FIN;
                    end else begin
                        state_n = STEP;
                        // Exact half-range tie stays on the increment side.
                        if (SHORTEST && (diff > HALF)) begin
                            dir_n = 1'b1;
                            rem_n = '0 - diff;
                        end else begin
                            dir_n = 1'b0;
                            rem_n = diff;
                        end
                    end
                end
            end
            STEP: begin
                if (abort) begin
                    state_n   = IDLE;
                    aborted_n = 1'b1;
                end else if (rem == WIDTH'(1)) begin
                    state_n = FIN;
                end else begin
                    rem_n = rem - WIDTH'(1);
                    if (GAP == 0) begin
                        state_n = STEP;
                    end else begin
                        state_n = WAIT;
                        gap_n   = GW'(GAP - 1);
                    end
                end
            end
            WAIT: begin
                if (abort) begin
                    state_n   = IDLE;
                    aborted_n = 1'b1;
                end else if (gap_cnt == '0) begin
                    state_n = STEP;
                end else begin
                    gap_n = gap_cnt - GW'(1);
                end
            end
            default: state_n = IDLE;
        endcase

        // Outputs are registered, so they are derived from the next state.
        inc_n   = (state_n == STEP) && !dir_n;
        dec_n   = (state_n == STEP) && dir_n;
        busy_n  = (state_n == STEP) || (state_n == WAIT);
        ready_n = (state_n == IDLE) || (state_n == FIN);
        done_n  = (state_n == FIN);
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state     <= IDLE;
            rem       <= '0;
            dir       <= 1'b0;
            gap_cnt   <= '0;
            shadow    <= '0;
            inc       <= 1'b0;
            dec       <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            aborted   <= 1'b0;
            err       <= 1'b0;
            tgt_ready <= 1'b1;
        end else begin
            state     <= state_n;
            rem       <= rem_n;
            dir       <= dir_n;
            gap_cnt   <= gap_n;
            inc       <= inc_n;
            dec       <= dec_n;
            busy      <= busy_n;
            done      <= done_n;
            aborted   <= aborted_n;
            tgt_ready <= ready_n;
            // Shadow moves on the same edge the counter samples the pulse.
            if (inc) begin
                shadow <= shadow + WIDTH'(1);
            end else if (dec) begin
                shadow <= shadow - WIDTH'(1);
            end
            if (cnt_fb != shadow) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cnt_step_gen.sv
module tb_cnt_step_gen;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Three configurations: 0 = GAP0/shortest, 1 = GAP2/shortest, 2 = GAP0/inc-only
    int gaps[3]      = '{0, 2, 0};
    int shortests[3] = '{1, 1, 0};

    logic       tgt_valid[3];
    logic [7:0] tgt_data[3];
    logic       abort_s[3];
    logic [7:0] cmask[3];
    logic [7:0] cnt[3];
    logic       tgt_ready[3], inc[3], dec[3], busy[3], done[3], aborted[3], err[3];
    logic [7:0] shadow[3];

    int n_checks = 0;
    int n_errors = 0;
    logic checking = 1'b0;

    cnt_step_gen #(.WIDTH(8), .GAP(0), .SHORTEST(1'b1)) u0 (
        .clk(clk), .rst_n(rst_n), .tgt_valid(tgt_valid[0]), .tgt_data(tgt_data[0]),
        .tgt_ready(tgt_ready[0]), .abort(abort_s[0]), .cnt_fb(cnt[0] ^ cmask[0]),
        .inc(inc[0]), .dec(dec[0]), .busy(busy[0]), .done(done[0]),
        .aborted(aborted[0]), .err(err[0]), .shadow(shadow[0]));

    cnt_step_gen #(.WIDTH(8), .GAP(2), .SHORTEST(1'b1)) u1 (
        .clk(clk), .rst_n(rst_n), .tgt_valid(tgt_valid[1]), .tgt_data(tgt_data[1]),
        .tgt_ready(tgt_ready[1]), .abort(abort_s[1]), .cnt_fb(cnt[1] ^ cmask[1]),
        .inc(inc[1]), .dec(dec[1]), .busy(busy[1]), .done(done[1]),
        .aborted(aborted[1]), .err(err[1]), .shadow(shadow[1]));

    cnt_step_gen #(.WIDTH(8), .GAP(0), .SHORTEST(1'b0)) u2 (
        .clk(clk), .rst_n(rst_n), .tgt_valid(tgt_valid[2]), .tgt_data(tgt_data[2]),
        .tgt_ready(tgt_ready[2]), .abort(abort_s[2]), .cnt_fb(cnt[2] ^ cmask[2]),
        .inc(inc[2]), .dec(dec[2]), .busy(busy[2]), .done(done[2]),
        .aborted(aborted[2]), .err(err[2]), .shadow(shadow[2]));

    // The driven up/down counter.
    always @(posedge clk or posedge rst_n) begin
        for (int i = 0; i < 3; i++) begin
            if (rst_n)       cnt[i] <= '0;
            else if (inc[i]) cnt[i] <= cnt[i] + 8'd1;
            else if (dec[i]) cnt[i] <= cnt[i] - 8'd1;
        end
    end

    // Walk schedule model: a walk of N steps accepted at cycle 0 pulses at
    // cycles 1 + k*(GAP+1), done follows the last pulse, abort ends it early.
    bit         m_walk[3], m_dir[3], m_fin[3], m_abt[3], m_err[3];
    int         m_rel[3], m_n[3];
    logic [7:0] m_sh[3];

    function automatic bit m_pulse(input int i);
        return m_walk[i] && (((m_rel[i] - 1) % (gaps[i] + 1)) == 0);
    endfunction

    always @(posedge clk or posedge rst_n) begin
        for (int i = 0; i < 3; i++) begin
            if (rst_n) begin
                m_walk[i] <= 1'b0; m_dir[i] <= 1'b0; m_fin[i] <= 1'b0;
                m_abt[i]  <= 1'b0; m_err[i] <= 1'b0; m_rel[i] <= 0;
                m_n[i]    <= 0;    m_sh[i]  <= '0;
            end else begin
                bit p;
                int k;
                int d;
                p = m_pulse(i);
                k = (m_rel[i] - 1) / (gaps[i] + 1);
                if ((cnt[i] ^ cmask[i]) != m_sh[i]) m_err[i] <= 1'b1;
                if (p) m_sh[i] <= m_dir[i] ? m_sh[i] - 8'd1 : m_sh[i] + 8'd1;
                m_fin[i] <= 1'b0;
                m_abt[i] <= 1'b0;
                if (m_walk[i]) begin
                    if (abort_s[i]) begin
                        m_walk[i] <= 1'b0; m_abt[i] <= 1'b1;
                    end else if (p && k == m_n[i] - 1) begin
                        m_walk[i] <= 1'b0; m_fin[i] <= 1'b1;
                    end else begin
                        m_rel[i] <= m_rel[i] + 1;
                    end
                end else if (tgt_valid[i]) begin
                    d = (int'(tgt_data[i]) - int'(m_sh[i]) + 256) % 256;
                    if (d == 0) begin
                        m_fin[i] <= 1'b1;
                    end else begin
                        m_walk[i] <= 1'b1;
                        m_rel[i]  <= 1;
                        if (shortests[i] == 1 && d > 128) begin
                            m_dir[i] <= 1'b1; m_n[i] <= 256 - d;
                        end else begin
                            m_dir[i] <= 1'b0; m_n[i] <= d;
                        end
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input int i, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s[%0d] at %0t: got %0d expected %0d", name, i, $time, act, exp);
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (checking) begin
            for (int i = 0; i < 3; i++) begin
                bit p;
                p = m_pulse(i);
                chk("inc",     i, int'(inc[i]),       int'(p && !m_dir[i]));
                chk("dec",     i, int'(dec[i]),       int'(p && m_dir[i]));
                chk("busy",    i, int'(busy[i]),      int'(m_walk[i]));
                chk("ready",   i, int'(tgt_ready[i]), int'(!m_walk[i]));
                chk("done",    i, int'(done[i]),      int'(m_fin[i]));
                chk("aborted", i, int'(aborted[i]),   int'(m_abt[i]));
                chk("shadow",  i, int'(shadow[i]),    int'(m_sh[i]));
                chk("err",     i, int'(err[i]),       int'(m_err[i]));
            end
        end
    end

    // Issue one target and follow the walk; cycle numbers count from acceptance.
    task automatic walk(input int i, input logic [7:0] tgt, input int abort_c,
                        input int corrupt_c, output int n_inc, output int n_dec,
                        output int done_c, output int abt_c, output int pmask,
                        output int err_c);
        bit fin;
        n_inc = 0; n_dec = 0; done_c = -1; abt_c = -1; pmask = 0; err_c = -1;
        fin = 1'b0;
        @(negedge clk); #1;
        tgt_valid[i] = 1'b1; tgt_data[i] = tgt;
        @(negedge clk);
        for (int c = 1; c < 1000; c++) begin
            if (inc[i]) n_inc++;
            if (dec[i]) n_dec++;
            if ((inc[i] || dec[i]) && c < 31) pmask |= (1 << c);
            if (err[i] && err_c < 0) err_c = c;
            if (done[i]) done_c = c;
            if (aborted[i]) abt_c = c;
            #1;
            tgt_valid[i] = 1'b0;
            abort_s[i]   = (c == abort_c);
            cmask[i]     = (c == corrupt_c) ? 8'($urandom_range(1, 255)) : 8'h00;
            if (done_c >= 0 || abt_c >= 0) begin
                fin = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!fin) chk("walk_timeout", i, 0, 1);
    endtask

    int ni, nd, dc, ac, pm, ec;

    initial begin
        for (int i = 0; i < 3; i++) begin
            tgt_valid[i] = 1'b0; tgt_data[i] = '0; abort_s[i] = 1'b0; cmask[i] = '0;
        end
        #1 rst_n = 1'b1;
        checking = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_shadow", 0, int'(shadow[0]), 0);
        chk("rst_ready",  0, int'(tgt_ready[0]), 1);
        chk("rst_busy",   0, int'(busy[0]), 0);
        #1 rst_n = 1'b0;

        // Plain increment walk.
        walk(0, 8'd5, -1, -1, ni, nd, dc, ac, pm, ec);
        chk("t1_inc", 0, ni, 5);  chk("t1_dec", 0, nd, 0);
        chk("t1_done", 0, dc, 6); chk("t1_shadow", 0, int'(shadow[0]), 5);
        chk("t1_err", 0, int'(err[0]), 0);

        // Shorter path downwards, wrapping through zero.
        walk(0, 8'd250, -1, -1, ni, nd, dc, ac, pm, ec);
        chk("t2_dec", 0, nd, 11); chk("t2_inc", 0, ni, 0);
        chk("t2_done", 0, dc, 12); chk("t2_shadow", 0, int'(shadow[0]), 250);

        // Target equal to shadow, then back-to-back accept in the done cycle.
        @(negedge clk); #1 tgt_valid[0] = 1'b1; tgt_data[0] = 8'd250;
        @(negedge clk);
        chk("t4_done", 0, int'(done[0]), 1); chk("t4_inc0", 0, int'(inc[0]), 0);
        #1 tgt_data[0] = 8'd252;
        @(negedge clk);
        chk("t4_busy", 0, int'(busy[0]), 1); chk("t4_inc", 0, int'(inc[0]), 1);
        #1 tgt_valid[0] = 1'b0;
        begin
            bit seen;
            seen = 1'b0;
            for (int c = 0; c < 20; c++) begin
                @(negedge clk);
                if (done[0]) begin seen = 1'b1; break; end
            end
            chk("t4_seen", 0, int'(seen), 1);
            chk("t4_shadow", 0, int'(shadow[0]), 252);
        end

        // Half-range tie goes up.
        walk(0, 8'd0, -1, -1, ni, nd, dc, ac, pm, ec);
        chk("t3_pre_inc", 0, ni, 4);
        walk(0, 8'd128, -1, -1, ni, nd, dc, ac, pm, ec);
        chk("t3_inc", 0, ni, 128); chk("t3_dec", 0, nd, 0); chk("t3_done", 0, dc, 129);

        // Increment-only configuration.
        walk(2, 8'd1, -1, -1, ni, nd, dc, ac, pm, ec);
        walk(2, 8'd128, -1, -1, ni, nd, dc, ac, pm, ec);
        chk("t3b_inc", 2, ni, 127); chk("t3b_dec", 2, nd, 0);
        walk(2, 8'd127, -1, -1, ni, nd, dc, ac, pm, ec);
        chk("t3c_inc", 2, ni, 255); chk("t3c_shadow", 2, int'(shadow[2]), 127);

        // GAP=2 schedule and abort.
        walk(1, 8'd3, -1, -1, ni, nd, dc, ac, pm, ec);
        chk("t5_pmask", 1, pm, 32'h92); chk("t5_done", 1, dc, 8);
        walk(1, 8'd0, -1, -1, ni, nd, dc, ac, pm, ec);
        chk("t5_back_dec", 1, nd, 3);
        walk(1, 8'd10, 4, -1, ni, nd, dc, ac, pm, ec);
        chk("t5a_inc", 1, ni, 2); chk("t5a_aborted", 1, ac, 5);
        chk("t5a_done", 1, dc, -1); chk("t5a_shadow", 1, int'(shadow[1]), 2);

        // Reset in the middle of a walk.
        @(negedge clk); #1 tgt_valid[1] = 1'b1; tgt_data[1] = 8'd50;
        @(negedge clk); #1 tgt_valid[1] = 1'b0;
        repeat (4) @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rstw_busy", 1, int'(busy[1]), 0);   chk("rstw_shadow", 1, int'(shadow[1]), 0);
        chk("rstw_inc", 1, int'(inc[1]), 0);     chk("rstw_ready", 1, int'(tgt_ready[1]), 1);
        chk("rstw_aborted", 1, int'(aborted[1]), 0);
        #1 rst_n = 1'b0;

        // Corrupted feedback for one cycle.
        walk(0, 8'd20, -1, 7, ni, nd, dc, ac, pm, ec);
        chk("t6_err_cyc", 0, ec, 8); chk("t6_done", 0, dc, 21);
        chk("t6_shadow", 0, int'(shadow[0]), 20);
        repeat (3) @(negedge clk);
        chk("t6_err_sticky", 0, int'(err[0]), 1);

        // Randomized traffic on all three instances.
        for (int cyc = 0; cyc < 6000; cyc++) begin
            @(negedge clk); #1;
            if (cyc == 3000) rst_n = 1'b1;
            if (cyc == 3002) rst_n = 1'b0;
            for (int i = 0; i < 3; i++) begin
                int off;
                tgt_valid[i] = ($urandom % 3) == 0;
                off = int'($urandom_range(0, 16)) - 8;
                if (($urandom % 8) == 0) tgt_data[i] = 8'($urandom);
                else                     tgt_data[i] = 8'(int'(m_sh[i]) + off);
                abort_s[i] = ($urandom % 50) == 0;
            end
        end
        @(negedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            tgt_valid[i] = 1'b0; abort_s[i] = 1'b0;
        end
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/cnt_step_gen.md
Name: cnt_step_gen

Overview:
- Stimulus-side partner for counter_inc_dec.
- Accepts a target count over a valid/ready handshake and emits single-cycle inc or dec pulses that walk the downstream up/down counter to that target.
- Keeps a shadow copy of the expected count and checks it against the counter's output every cycle, holding a sticky error flag on mismatch.
- Sits between a sequencer or bench and counter_inc_dec; its inc/dec outputs connect directly to the counter's inputs.

Parameters:
- WIDTH, 8, width of the counter, target, shadow and feedback.
- GAP, 0, idle cycles inserted between consecutive pulses (0 = one pulse per cycle).
- SHORTEST, 1, 1 = take the shorter modular direction; 0 = always increment.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, asynchronous, active-high.
- tgt_valid  input  1  target request valid.
- tgt_data  input  WIDTH  requested target count.
- tgt_ready  output  1  block can accept a target.
- abort  input  1  stop the current walk.
- cnt_fb  input  WIDTH  count output of the driven counter.
- inc  output  1  increment pulse to the counter.
- dec  output  1  decrement pulse to the counter.
- busy  output  1  walk in progress.
- done  output  1  one-cycle pulse when the target is reached.
- aborted  output  1  one-cycle pulse when a walk is aborted.
- err  output  1  sticky feedback mismatch.
- shadow  output  WIDTH  expected counter value.

Behaviour:
- Reset values: shadow=0, inc=0, dec=0, busy=0, done=0, aborted=0, err=0, tgt_ready=1, FSM=IDLE.
  - Reset asserted mid-walk aborts immediately; no done or aborted pulse is produced.
- All outputs are registered.
- inc and dec are never high in the same cycle.
- FSM states: IDLE, STEP, WAIT, FIN.
- IDLE:
  - tgt_ready=1.
  - A target is accepted on an edge where tgt_valid and tgt_ready are both high.
  - At acceptance, compute diff = (tgt_data - shadow) mod 2^WIDTH.
  - diff==0: go to FIN, no pulses.
  - SHORTEST=1 and diff <= 2^(WIDTH-1): direction inc, steps = diff. The exact tie at half range goes inc.
  - SHORTEST=1 and diff > 2^(WIDTH-1): direction dec, steps = 2^WIDTH - diff.
  - SHORTEST=0: direction inc, steps = diff.
- STEP:
  - inc or dec is high for exactly one cycle.
  - On that same edge the shadow updates ±1, wrapping mod 2^WIDTH.
  - This is the same edge on which the counter samples the pulse, so cnt_fb equals shadow in every cycle.
  - After the last step go to FIN.
  - Otherwise go to WAIT for GAP cycles, or straight back to STEP when GAP=0.
- Walk timing: the first pulse is in the cycle after acceptance. Pulse k (counting from 0) occurs in cycle 1 + k·(GAP+1).
- busy is high from the cycle after acceptance until the FIN cycle; tgt_ready is low over the same span.
- FIN:
  - done=1 for one cycle, busy=0, tgt_ready=1.
  - A new target may be accepted on the FIN edge (back-to-back walks).
  - Then return to IDLE.
- abort:
  - Sampled only in STEP or WAIT.
  - If abort is high on an edge, the pulse in that cycle, if any, still completes and shadow updates.
  - The next cycle has no pulse: aborted=1 for one cycle, busy=0, state returns to IDLE.
  - shadow keeps its partial value.
  - abort in IDLE or FIN is ignored.
- tgt_valid and tgt_data are ignored while busy; there is no queueing.
- Checker:
  - From the first edge after reset deassertion, each edge with cnt_fb != shadow sets err.
  - err stays high until reset.
  - shadow is not resynchronised to cnt_fb.

Test Plan:
1. Reset, GAP=0, then target 5 → inc high in cycles 1–5, dec never high, done in cycle 6, shadow=cnt_fb=5, err=0.
2. From 5, target 250 with SHORTEST=1 (diff=245) → 11 dec pulses wrapping through 0 and 255, final shadow=250, done pulses once.
3. From 0, target 128 (tie) → 128 inc pulses; same target with SHORTEST=0 from 1 → 127 inc pulses.
4. Target equal to the current shadow → no pulses, done in the cycle after acceptance; a second target presented during the done cycle is accepted immediately.
5. GAP=2, from 0, target 3 → pulses in cycles 1, 4 and 7, done in cycle 8; abort asserted in cycle 4 of a 10-step walk instead → 2 pulses, aborted in cycle 5, shadow=2.
6. Corrupt cnt_fb to a random value for one cycle mid-walk → err rises on that edge and stays high; the walk itself completes normally with a correct shadow.
